inport_fifo: RTL and testbench
==============================

Name: inport_fifo

Overview:
- Parametrised successor to the single-register input port.
- Buffers words from an external producer in a DEPTH-entry FIFO with a valid/ready handshake, then presents the oldest word to the CPU bus when Inportout is asserted.
- CPU pops one word per pop strobe, typically in the same T-step that loads Ra from the in-port.
- Mode parameter selects backpressure or overwrite-oldest with a sticky overflow flag.

Parameters:
- WIDTH, 32, data width of each entry and of the bus output.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- OVERWRITE, 0, 0 = backpressure when full; 1 = always accept, dropping the oldest entry when full.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  WIDTH  producer data.
- in_ready  output  1  FIFO accepts in_data this cycle. A push occurs on in_valid & in_ready.
- Inportout  input  1  bus-drive select from the control unit.
- pop  input  1  one-cycle strobe; removes the head entry at the rising edge.
- bus_data  output  WIDTH  head entry when Inportout=1 and not empty; otherwise 0.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky; set when an entry is dropped (OVERWRITE=1 only).
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (clear=1, asynchronous):
  - head and tail pointers = 0, count=0, overflow=0.
  - Outputs: empty=1, full=0, bus_data=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all entries; no push or pop completes on an edge where clear=1.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0. count is held separately; full/empty are derived from count, never from pointer equality.
- in_ready:
  - OVERWRITE=0: in_ready = ~full. No same-cycle bypass, so a pop does not make room for a push in the same cycle.
  - OVERWRITE=1: in_ready = 1.
- Latency: a word pushed at edge N is visible on bus_data (given Inportout=1) after edge N, provided it is the head. There is no write-to-read bypass through an empty FIFO in the push cycle.
- bus_data is combinational: Inportout & ~empty ? mem[head] : 0. It is zero-gated so it can be OR-ed or muxed onto the bus.
- Pop:
  - pop=1 and not empty: head+1, count-1.
  - pop=1 and empty: ignored; no state change and no error flag.
  - pop does not require Inportout.
- Simultaneous events at one edge:
  - Push and pop, 0<count<DEPTH: both occur, count unchanged.
  - Push and pop, count==0: pop ignored, push occurs, count=1.
  - Push and pop, count==DEPTH, OVERWRITE=1: normal pop plus push; count stays DEPTH; overflow is NOT set.
  - Push and pop, count==DEPTH, OVERWRITE=0: push is not accepted (in_ready=0); pop occurs; count=DEPTH-1.
  - Push without pop, count==DEPTH, OVERWRITE=1: oldest entry dropped (head+1), new word written at tail (tail+1), count stays DEPTH, overflow<=1.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Cleared only by ovf_clr or clear.
  - Stays 0 permanently when OVERWRITE=0.
- No combinational path from in_valid to in_ready.

Test Plan:
1. Reset and ordering: assert clear mid-cycle, push 0x11,0x22,0x33 on consecutive cycles, hold Inportout=1 and pop once per cycle. Required: count=0, empty=1 immediately on clear; count reaches 3; bus_data reads 0x11, 0x22, 0x33, then 0 with empty=1.
2. Backpressure (OVERWRITE=0, DEPTH=4): push 0xA0..0xA3, then hold in_valid=1 with 0xA4. Required: full=1, in_ready=0, 0xA4 not stored. Pop once; on the next cycle in_ready=1 and 0xA4 is accepted. Reading out yields 0xA1,0xA2,0xA3,0xA4.
3. Overwrite (OVERWRITE=1, DEPTH=4): push 0xB0..0xB4 with no pop. Required: overflow=1, count=4, pops yield 0xB1..0xB4. ovf_clr for one cycle leaves overflow=0.
4. Simultaneous push/pop:
   - At count=2: count stays 2 and FIFO order is preserved.
   - At count=0: count=1 and head equals the pushed word.
   - At full with OVERWRITE=1: overflow stays 0.
5. Wrap-around: 10 push/pop pairs of 0x8A+i across DEPTH=4. Required: every value read in order, with pointers wrapping and no loss.
6. Empty pop and bus gating: pop with count=0 produces no change in count or pointers. With data present and Inportout=0, bus_data=0; with Inportout=1, bus_data equals the head (e.g. 0x0000008A).

Source files
------------

// File: rtl/inport_fifo.sv
// ---------------------------------------------------------------------------
// inport_fifo
//
// Buffered CPU input port. An external producer pushes words into a
// DEPTH-entry circular buffer through a valid/ready handshake. The CPU
// sees the oldest word on bus_data while Inportout is asserted and removes
// it with a one-cycle pop strobe.
//
// OVERWRITE = 0 : producer is back-pressured while the buffer is full.
// OVERWRITE = 1 : producer is always accepted. A push into a full buffer
//                 with no pop drops the oldest word and sets the sticky
//                 overflow flag.
//
// Ports
//   Clock      in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   in_valid   in   producer offers in_data
//   in_data    in   producer word
//   in_ready   out  buffer accepts in_data this cycle
//   Inportout  in   drive the head word onto bus_data
//   pop        in   remove the head word at the next edge
//   bus_data   out  head word when Inportout & ~empty, else zero
//   empty      out  no valid entries
//   full       out  DEPTH valid entries
//   count      out  number of valid entries
//   overflow   out  sticky "an entry was dropped" flag
//   ovf_clr    in   synchronous clear of overflow
// ---------------------------------------------------------------------------
module inport_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                       Clock,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       Inportout,
    input  logic                       pop,
    output logic [WIDTH-1:0]           bus_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic push_req;
    logic pop_ok;
    logic drop;
    logic head_adv;

    // Occupancy comes from the separate counter, so a full buffer and an
    // empty one are never confused even though head == tail in both.
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready = (OVERWRITE != 0) ? 1'b1 : ~full;

    assign push_req = in_valid & in_ready;
    assign pop_ok   = pop & ~empty;

    // Overwrite of the oldest entry: only when full and the CPU is not
    // already making room with a pop in the same cycle.
    assign drop     = (OVERWRITE != 0) && push_req && full && !pop_ok;
    assign head_adv = pop_ok | drop;

    // Zero-gated so the port can be OR-ed onto a shared bus.
    assign bus_data = (Inportout && !empty) ? mem[head] : '0;

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (head_adv) begin
                head <= head + PTR_W'(1);
            end
            if (push_req) begin
                tail <= tail + PTR_W'(1);
            end
            // A push paired with a head advance (pop or drop) keeps count.
            if (push_req && !head_adv) begin
                count <= count + CNT_W'(1);
            end else if (!push_req && head_adv) begin
                count <= count - CNT_W'(1);
            end
            // Setting wins over a simultaneous clear request.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage holds data only; its contents after reset are don't-care.
    always_ff @(posedge Clock) begin
        if (push_req) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_inport_fifo.sv
module tb_inport_fifo;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          Clock = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          Inportout = 1'b0;
    logic          pop = 1'b0;
    logic          ovf_clr = 1'b0;

    logic          rdy0, emp0, full0, ovf0;
    logic [W-1:0]  bus0;
    logic [CW-1:0] cnt0;
    logic          rdy1, emp1, full1, ovf1;
    logic [W-1:0]  bus1;
    logic [CW-1:0] cnt1;

    always #5 Clock = ~Clock;

    inport_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) dut0 (
        .Clock(Clock), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .Inportout(Inportout), .pop(pop), .bus_data(bus0),
        .empty(emp0), .full(full0), .count(cnt0), .overflow(ovf0), .ovf_clr(ovf_clr)
    );

    inport_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) dut1 (
        .Clock(Clock), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .Inportout(Inportout), .pop(pop), .bus_data(bus1),
        .empty(emp1), .full(full1), .count(cnt1), .overflow(ovf1), .ovf_clr(ovf_clr)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: index 0 is the backpressure instance, 1 the overwrite
    // instance. Each FIFO is an ordered list, oldest word at index 0.
    logic [W-1:0] mdat [2][17];
    int           msz  [2];
    bit           movf [2];

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           io;
        bit           p;
        int           ecnt;
        logic [W-1:0] ebus;
        bit           erdy;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            msz[m]  = 0;
            movf[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            bit ow, rdy, push, popok, drp;
            ow    = (m == 1);
            rdy   = ow || (msz[m] < D);
            push  = in_valid && rdy;
            popok = pop && (msz[m] > 0);
            drp   = push && !popok && (msz[m] == D);
            if (popok || drp) begin
                for (int i = 0; i < 16; i++) mdat[m][i] = mdat[m][i+1];
                msz[m]--;
            end
            if (push) begin
                mdat[m][msz[m]] = in_data;
                msz[m]++;
            end
            if (drp) movf[m] = 1'b1;
            else if (ovf_clr) movf[m] = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("cnt0",  32'(cnt0),  32'(msz[0]));
        chk("emp0",  32'(emp0),  32'(msz[0] == 0));
        chk("full0", 32'(full0), 32'(msz[0] == D));
        chk("rdy0",  32'(rdy0),  32'(msz[0] < D));
        chk("bus0",  bus0, (Inportout && msz[0] > 0) ? mdat[0][0] : 32'h0);
        chk("ovf0",  32'(ovf0),  32'(movf[0]));
        chk("cnt1",  32'(cnt1),  32'(msz[1]));
        chk("emp1",  32'(emp1),  32'(msz[1] == 0));
        chk("full1", 32'(full1), 32'(msz[1] == D));
        chk("rdy1",  32'(rdy1),  32'h1);
        chk("bus1",  bus1, (Inportout && msz[1] > 0) ? mdat[1][0] : 32'h0);
        chk("ovf1",  32'(ovf1),  32'(movf[1]));
    endtask

    // Called just after a rising edge: apply inputs, then sit at the falling edge.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit io, input bit p, input bit oc);
        in_valid  = v;
        in_data   = d;
        Inportout = io;
        pop       = p;
        ovf_clr   = oc;
        @(negedge Clock);
    endtask

    task automatic step_edge();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] d, input bit io, input bit p, input bit oc);
        drive(v, d, io, p, oc);
        check_model();
        step_edge();
    endtask

    // Mid-cycle asynchronous clear, held across one edge with a push and
    // pop requested; neither may complete.
    task automatic do_clear();
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        pop       = 1'b1;
        Inportout = 1'b1;
        ovf_clr   = 1'b0;
        #2 clear = 1'b1;
        #1;
        chk("clr_cnt0",  32'(cnt0),  32'h0);
        chk("clr_emp0",  32'(emp0),  32'h1);
        chk("clr_full0", 32'(full0), 32'h0);
        chk("clr_rdy0",  32'(rdy0),  32'h1);
        chk("clr_bus0",  bus0,       32'h0);
        chk("clr_ovf0",  32'(ovf0),  32'h0);
        chk("clr_cnt1",  32'(cnt1),  32'h0);
        chk("clr_emp1",  32'(emp1),  32'h1);
        chk("clr_ovf1",  32'(ovf1),  32'h0);
        @(posedge Clock);
        #1;
        chk("clr_hold_cnt0", 32'(cnt0), 32'h0);
        chk("clr_hold_cnt1", 32'(cnt1), 32'h0);
        clear    = 1'b0;
        in_valid = 1'b0;
        pop      = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(bit v, logic [W-1:0] d, bit io, bit p, int ecnt, logic [W-1:0] ebus, bit erdy);
        vec_t r;
        r.v = v; r.d = d; r.io = io; r.p = p;
        r.ecnt = ecnt; r.ebus = ebus; r.erdy = erdy;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Ordering, then backpressure on the OVERWRITE=0 instance.
        // Expected values are the pre-edge outputs of dut0.
        tbl[0]  = mk(1, 32'h11, 1, 0, 0, 32'h00, 1);
        tbl[1]  = mk(1, 32'h22, 1, 0, 1, 32'h11, 1);
        tbl[2]  = mk(1, 32'h33, 1, 0, 2, 32'h11, 1);
        tbl[3]  = mk(0, 32'h00, 1, 1, 3, 32'h11, 1);
        tbl[4]  = mk(0, 32'h00, 1, 1, 2, 32'h22, 1);
        tbl[5]  = mk(0, 32'h00, 1, 1, 1, 32'h33, 1);
        tbl[6]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);
        tbl[7]  = mk(1, 32'hA0, 1, 0, 0, 32'h00, 1);
        tbl[8]  = mk(1, 32'hA1, 1, 0, 1, 32'hA0, 1);
        tbl[9]  = mk(1, 32'hA2, 1, 0, 2, 32'hA0, 1);
        tbl[10] = mk(1, 32'hA3, 1, 0, 3, 32'hA0, 1);
        tbl[11] = mk(1, 32'hA4, 1, 0, 4, 32'hA0, 0);
        tbl[12] = mk(1, 32'hA4, 1, 0, 4, 32'hA0, 0);
        tbl[13] = mk(1, 32'hA4, 1, 1, 4, 32'hA0, 0);
        tbl[14] = mk(1, 32'hA4, 1, 0, 3, 32'hA1, 1);
        tbl[15] = mk(0, 32'h00, 1, 1, 4, 32'hA1, 0);
        tbl[16] = mk(0, 32'h00, 1, 1, 3, 32'hA2, 1);
        tbl[17] = mk(0, 32'h00, 1, 1, 2, 32'hA3, 1);
        tbl[18] = mk(0, 32'h00, 1, 1, 1, 32'hA4, 1);
        tbl[19] = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);

        model_reset();
        @(posedge Clock);
        #1;
        do_clear();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].io, tbl[i].p, 0);
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_bus", i), bus0, tbl[i].ebus);
            chk($sformatf("tbl%0d_rdy", i), 32'(rdy0), 32'(tbl[i].erdy));
            check_model();
            step_edge();
        end

        // Overwrite: five pushes into the OVERWRITE=1 instance.
        do_clear();
        for (int i = 0; i < 5; i++) cycle(1, 32'hB0 + i, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("ow_ovf",  32'(ovf1),  32'h1);
        chk("ow_cnt",  32'(cnt1),  32'h4);
        chk("ow_full", 32'(full1), 32'h1);
        chk("ow_head", bus1,       32'hB1);
        check_model();
        step_edge();
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, 1, 1, 0);
            chk($sformatf("ow_pop%0d", i), bus1, 32'hB0 + i);
            check_model();
            step_edge();
        end
        drive(0, 0, 1, 0, 1);
        chk("ow_ovf_before_clr", 32'(ovf1), 32'h1);
        step_edge();
        drive(0, 0, 1, 0, 0);
        chk("ow_ovf_after_clr", 32'(ovf1), 32'h0);
        chk("ow_empty", 32'(emp1), 32'h1);
        step_edge();

        // Simultaneous push/pop at count 2.
        do_clear();
        cycle(1, 32'hC0, 1, 0, 0);
        cycle(1, 32'hC1, 1, 0, 0);
        drive(1, 32'hC2, 1, 1, 0);
        chk("pp2_cnt_pre", 32'(cnt0), 32'h2);
        step_edge();
        drive(0, 0, 1, 1, 0);
        chk("pp2_cnt", 32'(cnt0), 32'h2);
        chk("pp2_head", bus0, 32'hC1);
        step_edge();
        drive(0, 0, 1, 1, 0);
        chk("pp2_next", bus0, 32'hC2);
        step_edge();

        // Simultaneous push/pop at count 0: pop ignored.
        drive(1, 32'hD0, 1, 1, 0);
        chk("pp0_cnt_pre", 32'(cnt0), 32'h0);
        step_edge();
        drive(0, 0, 1, 0, 0);
        chk("pp0_cnt", 32'(cnt0), 32'h1);
        chk("pp0_head", bus0, 32'hD0);
        step_edge();
        cycle(0, 0, 1, 1, 0);

        // Simultaneous push/pop at full on the overwrite instance.
        do_clear();
        for (int i = 0; i < 4; i++) cycle(1, 32'hE0 + i, 1, 0, 0);
        drive(1, 32'hE4, 1, 1, 0);
        chk("ppf_cnt_pre", 32'(cnt1), 32'h4);
        check_model();
        step_edge();
        drive(0, 0, 1, 0, 0);
        chk("ppf_ovf",  32'(ovf1), 32'h0);
        chk("ppf_cnt",  32'(cnt1), 32'h4);
        chk("ppf_head", bus1,      32'hE1);
        chk("ppf_cnt0", 32'(cnt0), 32'h3);
        check_model();
        step_edge();

        // Wrap-around with bus gating and an empty pop up front.
        do_clear();
        drive(0, 0, 1, 1, 0);
        step_edge();
        drive(0, 0, 1, 0, 0);
        chk("epop_cnt", 32'(cnt0), 32'h0);
        chk("epop_emp", 32'(emp0), 32'h1);
        step_edge();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h8A + i, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d_gated", i), bus0, 32'h0);
            check_model();
            step_edge();
            drive(0, 0, 1, 1, 0);
            chk($sformatf("wrap%0d_read", i), bus0, 32'h8A + i);
            check_model();
            step_edge();
        end

        // Randomized traffic against the model.
        do_clear();
        for (int n = 0; n < 1500; n++) begin
            if (n % 400 == 399) do_clear();
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
